div_sgn_seq: RTL and testbench

Iterative signed divider for the arithmetic library: computes the truncating quotient and remainder of two two's-complement operands at one quotient bit per cycle, using restoring division on magnitudes. Complements the signed multiplier datapath as the divide unit of the same arithmetic unit. Operands enter and results leave over valid/ready handshakes, so it can sit behind an issue stage and ahead of a writeback stage.

---
 rtl/div_sgn_seq.sv | 126 ++++++++++++
 tb/tb_div_sgn_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_sgn_seq.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient
// bit per cycle, truncating quotient and dividend-signed remainder, valid/ready on both sides.
module div_sgn_seq #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] X,
  input  logic [width-1:0] Y,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] Q,
  output logic [width-1:0] R,
  output logic             DivZero
);

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_cnt = cw'(width - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [width-1:0] qd_r;      // dividend magnitude, quotient bits shift in at the LSB
  logic [width-1:0] ay_r;
  logic [width-1:0] rem_r;
  logic [cw-1:0]    cnt_r;
  logic             sx_r, sq_r, dz_r;

  logic [width-1:0] ax_s, ayin_s;
  logic [width:0]   shifted_s, diff_s;

  // Operand magnitudes and the trial subtraction for the current iteration
  always_comb begin
    ax_s      = X[width-1] ? -X : X;
    ayin_s    = Y[width-1] ? -Y : Y;
    shifted_s = {rem_r, qd_r[width-1]};
    diff_s    = shifted_s - {1'b0, ay_r};
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid_i) state_s = CALC;
        else            state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == last_cnt) state_s = DONE;
        else                   state_s = CALC;
      end
      DONE: begin
        if (out_ready_i) state_s = IDLE;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one restoring step per cycle in CALC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qd_r  <= '0;
      ay_r  <= '0;
      rem_r <= '0;
      cnt_r <= '0;
      sx_r  <= 1'b0;
      sq_r  <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            qd_r  <= ax_s;
            ay_r  <= ayin_s;
            rem_r <= '0;
            cnt_r <= '0;
            sx_r  <= X[width-1];
            sq_r  <= X[width-1] ^ Y[width-1];
            dz_r  <= (Y == '0);
          end
        end
        CALC: begin
          cnt_r <= cnt_r + cw'(1);
          if (!diff_s[width]) begin
            rem_r <= diff_s[width-1:0];
            qd_r  <= {qd_r[width-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[width-1:0];
            qd_r  <= {qd_r[width-2:0], 1'b0};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Sign fixup; a zero divisor leaves |X| in the remainder, so R reproduces X
  always_comb begin
    in_ready_o  = (state_r == IDLE);
    out_valid_o = (state_r == DONE);
    DivZero     = dz_r & (state_r == DONE);
    R           = sx_r ? -rem_r : rem_r;
    if (dz_r) begin
      Q = '1;
    end else if (sq_r) begin
      Q = -qd_r;
    end else begin
      Q = qd_r;
    end
  end

endmodule

// File: tb/tb_div_sgn_seq.sv
// Directed-vector bench for div_sgn_seq at width 8: latency, sign cases, divide by zero,
// overflow, back-pressure and mid-operation reset.
module tb_div_sgn_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] X, Y;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] Q, R;
  logic       DivZero;

  int n_chk  = 0;
  int n_fail = 0;

  div_sgn_seq #(.width(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .X           (X),
    .Y           (Y),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .Q           (Q),
    .R           (R),
    .DivZero     (DivZero)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int t;
    t = 0;
    while (!in_ready_o && t < 40) begin
      step();
      t++;
    end
    chk({tag, " ready"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    X = x;
    Y = y;
    step();
    in_valid_i = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk({tag, " early_valid"}, 32'(out_valid_o), 32'd0);
    step();
    chk({tag, " valid"}, 32'(out_valid_o), 32'd1);
    chk({tag, " Q"}, 32'(Q), 32'(eq));
    chk({tag, " R"}, 32'(R), 32'(er));
    chk({tag, " DivZero"}, 32'(DivZero), 32'(edz));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk({tag, " valid_drop"}, 32'(out_valid_o), 32'd0);
    chk({tag, " dz_drop"}, 32'(DivZero), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    X           = 8'h00;
    Y           = 8'h00;
    #12;
    chk("rst Q", 32'(Q), 32'd0);
    chk("rst R", 32'(R), 32'd0);
    chk("rst DivZero", 32'(DivZero), 32'd0);
    chk("rst out_valid", 32'(out_valid_o), 32'd0);
    chk("rst in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    run_div("7/2",     8'h07, 8'h02, 8'h03, 8'h01, 1'b0);
    run_div("-7/2",    8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
    run_div("7/-2",    8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
    run_div("-7/-2",   8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0);
    run_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run_div("-128/1",  8'h80, 8'h01, 8'h80, 8'h00, 1'b0);
    run_div("-128/-128", 8'h80, 8'h80, 8'h01, 8'h00, 1'b0);
    run_div("127/-128",  8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0);
    run_div("5/0",     8'h05, 8'h00, 8'hFF, 8'h05, 1'b1);
    run_div("-3/0",    8'hFD, 8'h00, 8'hFF, 8'hFD, 1'b1);

    // Back-pressure: result held while new operands are waved at the input
    in_valid_i = 1'b1;
    X = 8'h07;
    Y = 8'h02;
    step();
    in_valid_i = 1'b0;
    repeat (8) step();
    chk("bp valid", 32'(out_valid_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      X = 8'd50;
      Y = 8'd3;
      step();
      chk("bp Q", 32'(Q), 32'h03);
      chk("bp R", 32'(R), 32'h01);
      chk("bp valid_hold", 32'(out_valid_o), 32'd1);
      chk("bp in_ready", 32'(in_ready_o), 32'd0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("bp idle", 32'(in_ready_o), 32'd1);
    run_div("50/3", 8'd50, 8'd3, 8'd16, 8'd2, 1'b0);

    // Reset during CALC aborts without a result
    in_valid_i = 1'b1;
    X = 8'd100;
    Y = 8'd7;
    step();
    in_valid_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid_o), 32'd0);
    chk("abort Q", 32'(Q), 32'd0);
    chk("abort R", 32'(R), 32'd0);
    chk("abort in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
